rpn_stack_ctrl: RTL and testbench
=================================

Name: rpn_stack_ctrl

Overview:
- Parametrised LIFO operand stack for the RPN calculator; replaces the fixed 8-bit pointer-plus-RAM arrangement.
- Holds up to DEPTH words of WIDTH bits in a register array and presents top-of-stack (TOS) and next-of-stack (NOS) to the ALU every cycle.
- Executes single-cycle stack ops (push, pop, ALU replace, dup, swap, clear) with explicit full/empty status and sticky overflow/underflow error flags.
- Sits between the key/switch input decoder and the ALU / HEX display driver.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, maximum stack entries; must be >= 2.
- CW, $clog2(DEPTH+1), width of the count output (derived; do not override).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  qualifies op; sampled each rising edge.
- op  input  3  operation code (see Behaviour).
- din  input  WIDTH  push data, or ALU result for REPLACE.
- tos  output  WIDTH  top entry; 0 when count==0.
- nos  output  WIDTH  second entry; 0 when count<2.
- count  output  CW  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- ack  output  1  one-cycle pulse: the previous-cycle op executed.
- ovf  output  1  sticky overflow flag.
- unf  output  1  sticky underflow flag.

Behaviour:
- Reset (async assert, any time, including mid-op):
  - count=0, every array entry=0, ack=0, ovf=0, unf=0.
  - Result: tos=0, nos=0, empty=1, full=0.
- Op codes (executed only on a clk edge with op_valid=1). sp denotes count; entries are stk[0..sp-1], stk[sp-1] is top.
  - 000 NOP: no state change; ack=1.
  - 001 PUSH: requires sp<DEPTH. Writes stk[sp]=din, sp+=1.
  - 010 POP: requires sp>=1. sp-=1. The vacated entry is zeroed.
  - 011 REPLACE: requires sp>=2. Writes stk[sp-2]=din, sp-=1, zeroes the old top. Implements a binary ALU op; din is the ALU result computed from the current tos/nos.
  - 100 DUP: requires 1<=sp<DEPTH. Writes stk[sp]=stk[sp-1], sp+=1.
  - 101 SWAP: requires sp>=2. Exchanges stk[sp-1] and stk[sp-2].
  - 110 CLEAR: sp=0, all entries=0, ovf=0, unf=0.
  - 111 reserved: treated as NOP.
- Failed precondition (no state change, ack=0 next cycle):
  - PUSH or DUP when full sets ovf.
  - POP, REPLACE or SWAP with too few entries sets unf; DUP with sp==0 also sets unf.
- ack is registered, high exactly one cycle after an executed op. It is low after a failed op or when op_valid=0.
- Latency:
  - tos, nos, count, empty, full are combinational decodes of registered state.
  - They reflect an op in the cycle following the clk edge that executed it, so back-to-back ops every cycle are supported.
  - REPLACE reads tos/nos in the same cycle it is issued; no hazard, because state only updates at the edge.
- ovf and unf stay set until CLEAR or reset. CLEAR issued while flags are set clears them and acks.
- No wrap-around: count saturates by refusal, never by modulo.
- All arithmetic is unsigned at width CW; count never exceeds DEPTH.
- op_valid=0 means hold; op and din are don't-care.

Decomposition:
- Shared package rpn_pkg: op-code localparams OP_NOP, OP_PUSH, OP_POP, OP_REPLACE, OP_DUP, OP_SWAP, OP_CLEAR; a typedef for the 3-bit op.
- One sub-module, stack_ptr_ctr (parametrised CW/DEPTH): holds count; provides inc/dec/clear with async active-low reset; outputs empty/full.
- The top module holds the array, precondition checks, error flags and ack.

Test Plan (WIDTH=8, DEPTH=4):
- Reset then PUSH 0x05, PUSH 0x03 -> tos=0x03, nos=0x05, count=2, ack pulses after each push, empty=0.
- With [0x05,0x03], present din=tos+nos=0x08 and REPLACE -> tos=0x08, nos=0x00, count=1, ovf=unf=0.
- PUSH 0x11, 0x22, 0x33, 0x44, then PUSH 0x55 -> full=1, count=4, tos=0x44, ovf=1, no ack on the 5th push; then POP -> tos=0x33, ovf still 1.
- From empty: POP -> unf=1, count=0, ack=0. Then PUSH 0x07, DUP -> tos=nos=0x07. SWAP with [0x01,0x02] -> tos=0x01, nos=0x02.
- Flags set with 3 entries, then CLEAR -> count=0, tos=0, ovf=unf=0, ack=1. Next, with op_valid=0 for 3 cycles -> no change, ack=0.
- Assert reset_n low mid-cycle while a PUSH is presented with count=2 -> outputs go to reset values immediately, asynchronously. After release, the first valid PUSH 0x09 gives count=1, tos=0x09.

Source files
------------

// File: rtl/rpn_pkg.sv
// -----------------------------------------------------------------------------
// rpn_pkg
//   Shared definitions for the RPN calculator operand stack.
//   Contents:
//     op_t        - 3-bit stack operation code
//     OP_*        - operation code values
//     op_is_grow  - helper: op adds an entry when it executes
//     op_is_shrink- helper: op removes an entry when it executes
// -----------------------------------------------------------------------------
package rpn_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP     = 3'b000;
    localparam op_t OP_PUSH    = 3'b001;
    localparam op_t OP_POP     = 3'b010;
    localparam op_t OP_REPLACE = 3'b011;
    localparam op_t OP_DUP     = 3'b100;
    localparam op_t OP_SWAP    = 3'b101;
    localparam op_t OP_CLEAR   = 3'b110;
    localparam op_t OP_RSVD    = 3'b111;

    // PUSH and DUP each add one entry.
    function automatic logic op_is_grow(input op_t op);
        return (op == OP_PUSH) || (op == OP_DUP);
    endfunction

    // POP and REPLACE each remove one entry (REPLACE folds two into one).
    function automatic logic op_is_shrink(input op_t op);
        return (op == OP_POP) || (op == OP_REPLACE);
    endfunction

endpackage : rpn_pkg

// File: rtl/stack_ptr_ctr.sv
// -----------------------------------------------------------------------------
// stack_ptr_ctr
//   Entry counter for the operand stack. Holds the number of valid entries
//   and decodes empty/full from it.
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset (count -> 0)
//     inc      in   add one entry (ignored when full)
//     dec      in   remove one entry (ignored when empty)
//     clr      in   drop all entries; wins over inc/dec
//     count    out  valid entries, 0..DEPTH
//     empty    out  count == 0
//     full     out  count == DEPTH
// -----------------------------------------------------------------------------
module stack_ptr_ctr #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // The controller never requests inc and dec together, but the guards
    // keep the count inside 0..DEPTH no matter what drives this block.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + CW'(1);
        end else if (dec && !inc && !empty) begin
            count <= count - CW'(1);
        end
    end

endmodule : stack_ptr_ctr

// File: rtl/rpn_stack_ctrl.sv
// -----------------------------------------------------------------------------
// rpn_stack_ctrl
//   LIFO operand stack for the RPN calculator. Holds up to DEPTH words in a
//   register array and presents top-of-stack and next-of-stack to the ALU
//   every cycle. Executes one stack op per clock with precondition checks,
//   full/empty status and sticky overflow/underflow flags.
//   Parameters:
//     WIDTH  data word width
//     DEPTH  maximum entries (>= 2)
//     CW     count width, derived from DEPTH; leave at default
//   Ports:
//     clk       in   system clock
//     reset_n   in   asynchronous active-low reset
//     op_valid  in   qualifies op/din on the rising edge
//     op        in   operation code (rpn_pkg::OP_*)
//     din       in   push data, or ALU result for REPLACE
//     tos       out  top entry, 0 when empty
//     nos       out  second entry, 0 when fewer than two entries
//     count     out  valid entries
//     empty     out  count == 0
//     full      out  count == DEPTH
//     ack       out  high for one cycle after an op that executed
//     ovf       out  sticky: PUSH/DUP refused because full
//     unf       out  sticky: op refused because too few entries
// -----------------------------------------------------------------------------
module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ack,
    output logic             ovf,
    output logic             unf
);

    op_t              op_c;
    logic [WIDTH-1:0] stk     [DEPTH];
    logic [WIDTH-1:0] stk_nxt [DEPTH];
    logic [CW-1:0]    sp_m1;      // index of top entry
    logic [CW-1:0]    sp_m2;      // index of second entry
    logic             has2;
    logic             exec;       // op passes its precondition this cycle
    logic             ovf_set;
    logic             unf_set;
    logic             is_clear;

    assign op_c     = op_t'(op);
    assign sp_m1    = count - CW'(1);
    assign sp_m2    = count - CW'(2);
    assign has2     = (count >= CW'(2));
    assign is_clear = exec && (op_c == OP_CLEAR);

    // ------------------------------------------------------------------
    // Entry counter
    // ------------------------------------------------------------------
    stack_ptr_ctr #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (exec && op_is_grow(op_c)),
        .dec     (exec && op_is_shrink(op_c)),
        .clr     (is_clear),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    // ------------------------------------------------------------------
    // Precondition check. A refused op leaves all state alone and only
    // raises the matching sticky flag.
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        exec    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (op_valid) begin
            unique case (op_c)
                OP_PUSH: begin
                    if (!full) exec    = 1'b1;
                    else       ovf_set = 1'b1;
                end
                OP_POP: begin
                    if (!empty) exec    = 1'b1;
                    else        unf_set = 1'b1;
                end
                OP_REPLACE, OP_SWAP: begin
                    if (has2) exec    = 1'b1;
                    else      unf_set = 1'b1;
                end
                OP_DUP: begin
                    if (empty)     unf_set = 1'b1;
                    else if (full) ovf_set = 1'b1;
                    else           exec    = 1'b1;
                end
                // NOP, CLEAR and the reserved code always execute.
                default: exec = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TOS/NOS decode. Indices are compared against each entry number so
    // the CW-bit pointer never indexes the array directly.
    // ------------------------------------------------------------------
    always_comb begin
        tos = '0;
        nos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!empty && (CW'(i) == sp_m1)) tos = stk[i];
            if (has2   && (CW'(i) == sp_m2)) nos = stk[i];
        end
    end

    // ------------------------------------------------------------------
    // Next array contents. Vacated entries are zeroed so a later PUSH or
    // a debug read never exposes stale operands.
    // ------------------------------------------------------------------
    always_comb begin
        stk_nxt = stk;
        if (exec) begin
            for (int i = 0; i < DEPTH; i++) begin
                unique case (op_c)
                    OP_PUSH: begin
                        if (CW'(i) == count) stk_nxt[i] = din;
                    end
                    OP_POP: begin
                        if (CW'(i) == sp_m1) stk_nxt[i] = '0;
                    end
                    OP_REPLACE: begin
                        // din is the ALU result of the current tos/nos.
                        if (CW'(i) == sp_m2) stk_nxt[i] = din;
                        if (CW'(i) == sp_m1) stk_nxt[i] = '0;
                    end
                    OP_DUP: begin
                        if (CW'(i) == count) stk_nxt[i] = tos;
                    end
                    OP_SWAP: begin
                        if (CW'(i) == sp_m1) stk_nxt[i] = nos;
                        if (CW'(i) == sp_m2) stk_nxt[i] = tos;
                    end
                    OP_CLEAR: begin
                        stk_nxt[i] = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the array is a small register file, not RAM, so it is reset
    // explicitly; the outputs must read 0 right after reset without relying
    // on the count to mask stale contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stk <= '{default: '0};
        end else begin
            stk <= stk_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Acknowledge and sticky error flags. CLEAR always executes, so it
    // both clears the flags and acks even when a flag was set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack <= 1'b0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ack <= exec;
            if (is_clear) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end else begin
                if (ovf_set) ovf <= 1'b1;
                if (unf_set) unf <= 1'b1;
            end
        end
    end

endmodule : rpn_stack_ctrl

// File: tb/tb_rpn_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rpn_stack_ctrl
//   Scoreboard bench for rpn_stack_ctrl (WIDTH=8, DEPTH=4). A queue-based
//   reference stack predicts the visible state after each clock; expected
//   entries are queued at issue time and a monitor on the falling edge pops
//   and compares them once the consuming rising edge has passed.
// -----------------------------------------------------------------------------
module tb_rpn_stack_ctrl;
    import rpn_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef logic [WIDTH-1:0] word_t;

    logic             clk      = 1'b0;
    logic             reset_n  = 1'b0;
    logic             op_valid = 1'b0;
    logic [2:0]       op       = OP_NOP;
    logic [WIDTH-1:0] din      = '0;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ack;
    logic             ovf;
    logic             unf;

    always #5 clk = ~clk;

    rpn_stack_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .op       (op),
        .din      (din),
        .tos      (tos),
        .nos      (nos),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .ack      (ack),
        .ovf      (ovf),
        .unf      (unf)
    );

    // ------------------------------------------------------------------
    // Counters and compare helper
    // ------------------------------------------------------------------
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a plain queue, back = top of stack.
    // ------------------------------------------------------------------
    word_t m_st[$];
    bit    m_ovf;
    bit    m_unf;

    function automatic void m_reset();
        m_st.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic word_t m_tos();
        return (m_st.size() >= 1) ? m_st[m_st.size()-1] : word_t'(0);
    endfunction

    function automatic word_t m_nos();
        return (m_st.size() >= 2) ? m_st[m_st.size()-2] : word_t'(0);
    endfunction

    // Applies one op to the model; returns whether it executed.
    function automatic bit m_apply(input bit v, input op_t o, input word_t d);
        int    n;
        word_t t;
        n = m_st.size();
        if (!v) return 1'b0;
        case (o)
            OP_PUSH: begin
                if (n < DEPTH) begin m_st.push_back(d); return 1'b1; end
                m_ovf = 1'b1; return 1'b0;
            end
            OP_POP: begin
                if (n >= 1) begin void'(m_st.pop_back()); return 1'b1; end
                m_unf = 1'b1; return 1'b0;
            end
            OP_REPLACE: begin
                if (n >= 2) begin
                    void'(m_st.pop_back());
                    m_st[n-2] = d;
                    return 1'b1;
                end
                m_unf = 1'b1; return 1'b0;
            end
            OP_DUP: begin
                if (n == 0)     begin m_unf = 1'b1; return 1'b0; end
                if (n == DEPTH) begin m_ovf = 1'b1; return 1'b0; end
                m_st.push_back(m_st[n-1]);
                return 1'b1;
            end
            OP_SWAP: begin
                if (n >= 2) begin
                    t         = m_st[n-1];
                    m_st[n-1] = m_st[n-2];
                    m_st[n-2] = t;
                    return 1'b1;
                end
                m_unf = 1'b1; return 1'b0;
            end
            OP_CLEAR: begin
                m_reset();
                return 1'b1;
            end
            default: return 1'b1;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int unsigned cyc;
        string       tag;
        word_t       tos;
        word_t       nos;
        int          count;
        bit          ack;
        bit          ovf;
        bit          unf;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of stimulus (called just after a rising edge), queue
    // the predicted post-edge state, then step to just after the next edge.
    task automatic issue(input bit v, input op_t o, input word_t d, input string tag);
        exp_t e;
        bit   a;
        op_valid = v;
        op       = o;
        din      = d;
        a        = m_apply(v, o, d);
        e.cyc    = cyc + 1;
        e.tag    = tag;
        e.tos    = m_tos();
        e.nos    = m_nos();
        e.count  = m_st.size();
        e.ack    = a;
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        issue(1'b0, op_t'($urandom_range(0, 7)), word_t'($urandom), tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check({tag, ".sb_left"}, sb.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check({e.tag, ".tos"},   tos,   e.tos);
                check({e.tag, ".nos"},   nos,   e.nos);
                check({e.tag, ".count"}, count, e.count);
                check({e.tag, ".empty"}, empty, (e.count == 0));
                check({e.tag, ".full"},  full,  (e.count == DEPTH));
                check({e.tag, ".ack"},   ack,   e.ack);
                check({e.tag, ".ovf"},   ovf,   e.ovf);
                check({e.tag, ".unf"},   unf,   e.unf);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, ".tos"},   tos,   0);
        check({tag, ".nos"},   nos,   0);
        check({tag, ".count"}, count, 0);
        check({tag, ".empty"}, empty, 1);
        check({tag, ".full"},  full,  0);
        check({tag, ".ack"},   ack,   0);
        check({tag, ".ovf"},   ovf,   0);
        check({tag, ".unf"},   unf,   0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int    r;
        op_t   o;
        word_t d;

        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset_n = 1'b1;

        // Push two, then fold them with an ALU add via REPLACE.
        issue(1, OP_PUSH, 8'h05, "push05");
        issue(1, OP_PUSH, 8'h03, "push03");
        issue(1, OP_REPLACE, m_tos() + m_nos(), "replace_add");

        // Fill to DEPTH, refuse the fifth push, then pop.
        issue(1, OP_CLEAR, 8'h00, "clr1");
        issue(1, OP_PUSH, 8'h11, "fill11");
        issue(1, OP_PUSH, 8'h22, "fill22");
        issue(1, OP_PUSH, 8'h33, "fill33");
        issue(1, OP_PUSH, 8'h44, "fill44");
        issue(1, OP_PUSH, 8'h55, "push_full");
        issue(1, OP_DUP,  8'h00, "dup_full");
        issue(1, OP_POP,  8'h00, "pop_after_ovf");

        // Underflow from empty, DUP, SWAP.
        issue(1, OP_CLEAR,   8'h00, "clr2");
        issue(1, OP_POP,     8'h00, "pop_empty");
        issue(1, OP_DUP,     8'h00, "dup_empty");
        issue(1, OP_PUSH,    8'h07, "push07");
        issue(1, OP_DUP,     8'h00, "dup07");
        issue(1, OP_SWAP,    8'h00, "swap_one");
        issue(1, OP_REPLACE, 8'hEE, "replace_one");
        issue(1, OP_CLEAR,   8'h00, "clr3");
        issue(1, OP_PUSH,    8'h01, "push01");
        issue(1, OP_PUSH,    8'h02, "push02");
        issue(1, OP_SWAP,    8'h00, "swap");
        issue(1, OP_NOP,     8'hAB, "nop");
        issue(1, OP_RSVD,    8'hCD, "reserved");

        // Flags set with three entries, CLEAR drops them and acks.
        issue(1, OP_PUSH,  8'h03, "push3rd");
        issue(1, OP_PUSH,  8'h04, "push4th");
        issue(1, OP_PUSH,  8'h99, "ovf_push");
        issue(1, OP_POP,   8'h00, "pop_to3");
        issue(1, OP_CLEAR, 8'h00, "clr_flags");
        idle("idle1");
        idle("idle2");
        idle("idle3");

        // Randomized ops against the model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            if      (r <= 4)  o = OP_PUSH;
            else if (r <= 6)  o = OP_POP;
            else if (r <= 8)  o = OP_REPLACE;
            else if (r <= 10) o = OP_DUP;
            else if (r <= 12) o = OP_SWAP;
            else if (r == 13) o = OP_CLEAR;
            else if (r == 14) o = OP_NOP;
            else              o = OP_RSVD;
            d = (o == OP_REPLACE) ? word_t'(m_tos() + m_nos()) : word_t'($urandom);
            issue($urandom_range(0, 7) != 0, o, d, "rand");
        end
        drain("rand");

        // Asynchronous reset mid-cycle while a PUSH is presented at count=2.
        issue(1, OP_CLEAR, 8'h00, "clr4");
        issue(1, OP_PUSH,  8'h0A, "pre_rst_a");
        issue(1, OP_PUSH,  8'h0B, "pre_rst_b");
        drain("pre_rst");
        op_valid = 1'b1;
        op       = OP_PUSH;
        din      = 8'hAA;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        op_valid = 1'b0;
        reset_n  = 1'b1;
        m_reset();
        issue(1, OP_PUSH, 8'h09, "post_rst_push");
        idle("post_rst_idle");
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_rpn_stack_ctrl
